// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_WAIT,
    S_FULL,
    S_DROP
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0004;
  localparam logic [31:0] NOP_WORD           = 32'h0000_0000;

  // One IF/ID payload: instruction word plus its PC+4.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc4;
  } fetch_pkt_t;

endpackage

// File: rtl/if_fetch_unit_skid.sv
// One-entry ir/pc4 holding register. Catches a response that arrives
// while IF/ID is stalled and the fresh slot is already occupied.
module fetch_skid_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       unload_i,
  input  logic       clear_i,
  input  fetch_pkt_t pkt_i,
  output fetch_pkt_t pkt_o,
  output logic       valid_o
);

  fetch_pkt_t pkt_q, pkt_d;
  logic       valid_q, valid_d;

  always_comb begin
    pkt_d   = pkt_q;
    valid_d = valid_q;
    if (load_i) begin
      pkt_d   = pkt_i;
      valid_d = 1'b1;
    end
    // clear wins over a same-cycle load
    if (clear_i || unload_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
    end
  end

  assign pkt_o   = pkt_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding an enable-less IF/ID register.
// Optional imem response watchdog: define IMEM_TIMEOUT_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR     = EXC_VECTOR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_plus_4,
  output logic [31:0] IR,
  output logic        IF_ID_flush,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  fetch_pkt_t   fresh_q, fresh_d;
  fetch_pkt_t   mirror_q, mirror_d;
  logic         valid_q, valid_d;
  fetch_pkt_t   out_pkt, rsp_pkt, skid_pkt;
  logic         skid_v, skid_load, skid_unload, skid_clear;
  logic         req, flush, exc_any, timeout, outstanding;

  assign outstanding = (state_q == S_WAIT) || (state_q == S_DROP);
  assign exc_any     = exc_valid | timeout;
  assign flush       = redirect_valid | exc_any;
  assign rsp_pkt     = {imem_rdata, pc_q};

  // While stalled, re-present what IF/ID already holds so it keeps it.
  always_comb begin
    if (stall)        out_pkt = mirror_q;
    else if (valid_q) out_pkt = fresh_q;
    else              out_pkt = {NOP_WORD, NOP_WORD};
  end

  assign mirror_d    = flush ? '0 : out_pkt;
  assign IR          = out_pkt.ir;
  assign PC_plus_4   = out_pkt.pc4;
  assign IF_ID_flush = flush;
  assign imem_addr   = pc_q;
  // Gated by reset so the strobe drops the moment reset asserts.
  assign imem_req    = reset & req;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fresh_d     = fresh_q;
    valid_d     = stall ? valid_q : 1'b0;
    req         = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    case (state_q)
      S_BOOT: begin
        req     = 1'b1;
        state_d = S_WAIT;
      end
      S_IDLE: begin
        if (!(valid_q && stall)) begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (!stall) begin
            fresh_d = rsp_pkt;
            valid_d = 1'b1;
            req     = 1'b1;
          end else if (!valid_q) begin
            fresh_d = rsp_pkt;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            skid_load = 1'b1;
            state_d   = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (!stall) begin
          fresh_d     = skid_pkt;
          valid_d     = skid_v;
          skid_unload = 1'b1;
          req         = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (req) pc_d = pc_q + 32'd4;

    // Redirects beat stalls; a live request becomes stale and is drained in S_DROP.
    if (flush) begin
      req         = 1'b0;
      valid_d     = 1'b0;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b1;
      pc_d        = exc_any ? EXC_VECTOR : redirect_target;
      state_d     = (outstanding && !imem_rvalid) ? S_DROP : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      fresh_q  <= '0;
      valid_q  <= 1'b0;
      mirror_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fresh_q  <= fresh_d;
      valid_q  <= valid_d;
      mirror_q <= mirror_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .pkt_i    (rsp_pkt),
    .pkt_o    (skid_pkt),
    .valid_o  (skid_v)
  );

`ifdef IMEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_q;

  assign timeout = outstanding && !imem_rvalid && (wcnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Counts consecutive unanswered cycles within one S_WAIT/S_DROP stay.
  always_comb begin
    wcnt_d = wcnt_q + CW'(1);
    if (!outstanding || imem_rvalid || timeout || (state_d != state_q)) wcnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_q | timeout;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed + randomized bench for if_fetch_unit against a queue-based fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] EXC_VEC = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        exc_valid = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, IF_ID_flush, fetch_err;
  logic [31:0] imem_addr, PC_plus_4, IR;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .PC_plus_4       (PC_plus_4),
    .IR              (IR),
    .IF_ID_flush     (IF_ID_flush),
    .fetch_err       (fetch_err)
  );

  // Reference model: pending deliveries are a queue, IF/ID copy is m_mir.
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  logic [63:0] m_mir;
  bit          m_out, m_stale, m_err;
`ifdef IMEM_TIMEOUT_EN
  localparam int TO_CYC = 64;
  int          m_wcnt;
`endif

  // Memory responder
  bit          mem_pend, junk_next;
  int          mem_lat, lat_mode;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] + 16'h2008, a[15:0] ^ 16'h0005};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_mir = 64'd0;
    m_out = 0;
    m_stale = 0;
    m_err = 0;
`ifdef IMEM_TIMEOUT_EN
    m_wcnt = 0;
`endif
    mem_pend = 0;
  endtask

  task automatic cycle();
    logic [31:0] e_ir, e_pc4;
    logic [63:0] head;
    bit to, fl, resp_ok, out_after, issue;
    int occ;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    if (junk_next) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      junk_next   = 0;
    end else if (mem_pend) begin
      mem_lat--;
      if (mem_lat <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pend    = 0;
      end
    end
    @(negedge clk);
    to = 0;
`ifdef IMEM_TIMEOUT_EN
    to = m_out && !imem_rvalid && (m_wcnt == TO_CYC - 1);
`endif
    fl   = redirect_valid || exc_valid || to;
    head = (m_q.size() > 0) ? m_q[0] : 64'd0;
    {e_ir, e_pc4} = stall ? m_mir : head;
    resp_ok   = m_out && imem_rvalid && !m_stale && !fl;
    out_after = m_out && !imem_rvalid;
    occ   = m_q.size() - ((!stall && m_q.size() > 0) ? 1 : 0) + (resp_ok ? 1 : 0);
    // A new request needs the port free (a stale answer does not free it this cycle)
    issue = !fl && !(m_out && (m_stale || !imem_rvalid)) && (!stall || occ == 0);
    chk("IR", IR, e_ir);
    chk("PC_plus_4", PC_plus_4, e_pc4);
    chk("IF_ID_flush", 32'(IF_ID_flush), 32'(fl));
    chk("imem_req", 32'(imem_req), 32'(issue));
    if (issue) chk("imem_addr", imem_addr, m_pc);
    chk("fetch_err", 32'(fetch_err), 32'(m_err));

    m_mir = fl ? 64'd0 : {e_ir, e_pc4};
`ifdef IMEM_TIMEOUT_EN
    if (!m_out || imem_rvalid || to || (fl && !m_stale)) m_wcnt = 0;
    else m_wcnt++;
`endif
    if (to) m_err = 1;
    if (fl) begin
      m_q.delete();
      m_pc = (exc_valid || to) ? EXC_VEC : redirect_target;
      if (out_after) m_stale = 1;
      else begin
        m_out = 0;
        m_stale = 0;
      end
    end else begin
      if (!stall && m_q.size() > 0) void'(m_q.pop_front());
      if (resp_ok) m_q.push_back({imem_rdata, m_pc});
      if (m_out && imem_rvalid) begin
        m_out = 0;
        m_stale = 0;
      end
      if (issue) begin
        m_out    = 1;
        m_stale  = 0;
        mem_pend = 1;
        mem_addr = m_pc;
        mem_lat  = (lat_mode == 0) ? int'($urandom_range(4, 1)) : lat_mode;
        m_pc     = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt, input bit exc);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    exc_valid       = exc;
    cycle();
    redirect_valid  = 1'b0;
    exc_valid       = 1'b0;
  endtask

  initial begin
    model_reset();
    junk_next = 0;
    lat_mode  = 1;
    reset = 1'b0;
    #12;
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_IR", IR, 32'h0);
    chk("rst_PC_plus_4", PC_plus_4, 32'h0);
    chk("rst_flush", 32'(IF_ID_flush), 32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Latency-1 streaming from reset
    cycle();
    cycle();
    chk("first_IR", IR, 32'h2008_0005);
    chk("first_PC_plus_4", PC_plus_4, 32'h4);
    repeat (4) cycle();

    // Stall across a response, then release into a latency-3 request
    stall = 1'b1;
    repeat (3) cycle();
    stall = 1'b0;
    lat_mode = 3;
    cycle();

    // Redirect while waiting; junk response must be dropped
    redirect(32'h0000_0100, 1'b0);
    repeat (5) cycle();

    // Exception beats a same-cycle redirect
    lat_mode = 1;
    redirect(32'h0000_0200, 1'b1);
    repeat (4) cycle();

    // PC wrap and unaligned target
    redirect(32'hFFFF_FFF8, 1'b0);
    repeat (5) cycle();
    redirect(32'h0000_0102, 1'b0);
    repeat (4) cycle();

    // Randomized traffic
    lat_mode = 0;
    repeat (400) begin
      stall           = ($urandom_range(99) < 30);
      redirect_valid  = ($urandom_range(99) < 5);
      exc_valid       = ($urandom_range(99) < 2);
      redirect_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      cycle();
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    exc_valid = 1'b0;

    // Asynchronous reset while a request is outstanding
    lat_mode = 3;
    for (int i = 0; i < 20 && !(m_out && !m_stale && mem_lat >= 2); i++) cycle();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_imem_req", 32'(imem_req), 32'h0);
    chk("async_rst_IR", IR, 32'h0);
    chk("async_rst_PC_plus_4", PC_plus_4, 32'h0);
    model_reset();
    junk_next = 1;
    lat_mode  = 1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) cycle();

`ifdef IMEM_TIMEOUT_EN
    // Memory goes silent: watchdog must flag and vector to EXC_VEC
    lat_mode = 1000;
    repeat (70) cycle();
    chk("timeout_fetch_err", 32'(fetch_err), 32'h1);
    mem_lat  = 1;
    lat_mode = 1;
    repeat (4) cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to a variable-latency instruction memory (single outstanding request, back-to-back capable).
- Delivers IR / PC_plus_4 and IF_ID_flush to IF/ID, and absorbs hazard-unit stalls and EX-stage redirects.
- IF/ID has no enable, so this block stalls it by re-presenting IF/ID's current contents.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- EXC_VECTOR, 32'h8000_0004, target on exc_valid.
- TIMEOUT_CYCLES, 64, imem response watchdog limit (optional feature only).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold IF/ID contents this edge.
- redirect_valid  in  1  branch/jump taken in EX.
- redirect_target  in  32  new PC for redirect_valid.
- exc_valid  in  1  exception; forces PC to EXC_VECTOR.
- imem_req  out  1  request strobe, one cycle per request.
- imem_addr  out  32  request address, valid with imem_req.
- imem_rvalid  in  1  response strobe, at least 1 cycle after req.
- imem_rdata  in  32  instruction, valid with imem_rvalid.
- PC_plus_4  out  32  to IF/ID.
- IR  out  32  to IF/ID.
- IF_ID_flush  out  1  to IF/ID.
- fetch_err  out  1  sticky watchdog error (0 without optional feature).

Behaviour:
- Registers:
  - pc: next address to request; incremented by 4 on every issued request.
  - fresh ir/pc4 + valid_q: next instruction to deliver.
  - skid ir/pc4 + skid_v: one-entry buffer.
  - mirror ir/pc4: copy of IF/ID contents.
  - state.
- Reset (async, reset=0): pc=RESET_PC, state=S_BOOT, all data registers 0, valid_q=skid_v=0, imem_req=0, fetch_err=0.
- Response PC_plus_4 = pc at response time. Only one request is ever outstanding.
- Outputs, combinational from registers:
  - stall=1: IR/PC_plus_4 = mirror.
  - stall=0, valid_q=1: IR/PC_plus_4 = fresh.
  - stall=0, valid_q=0: IR/PC_plus_4 = 0 (bubble).
- IF_ID_flush = redirect_valid | exc_valid.
- Mirror update every edge: mirror <= IF_ID_flush ? 0 : (IR, PC_plus_4).
- Fresh is consumed at any non-stall edge.
- States:
  - S_BOOT: imem_req=1, addr=pc -> S_WAIT.
  - S_IDLE: no request outstanding. If valid_q&stall, stay with no req. Else req at pc -> S_WAIT.
  - S_WAIT: request outstanding. Until rvalid, stay.
    - rvalid & !stall: fresh<=rdata, valid_q=1, same-cycle req at pc -> S_WAIT. Latency-1 memory yields 1 IPC.
    - rvalid & stall & !valid_q: load fresh -> S_IDLE.
    - rvalid & stall & valid_q: load skid -> S_FULL, no req.
  - S_FULL: while stall, hold. On stall=0: fresh<=skid, skid_v=0, req at pc -> S_WAIT.
  - S_DROP: stale request outstanding. On rvalid, discard data -> S_IDLE.
- Redirect (exc_valid > redirect_valid), any state, overrides stall:
  - pc <= target, valid_q=0, skid_v=0, imem_req forced 0 that cycle.
  - Outstanding request with no rvalid this cycle -> S_DROP; otherwise -> S_IDLE, discarding any same-cycle data.
  - Redirect in S_DROP: update pc, stay S_DROP unless rvalid that cycle.
- pc arithmetic is 32-bit and wraps modulo 2^32. Bits [1:0] are passed unchanged.

Optional Feature:
- IMEM_TIMEOUT_EN defined:
  - Cycle counter runs in S_WAIT/S_DROP and clears on rvalid or leaving the state.
  - Reaching TIMEOUT_CYCLES sets fetch_err (sticky until reset) and applies an internal exception redirect (pc=EXC_VECTOR, IF_ID_flush pulse, -> S_DROP).
- Undefined: no counter, fetch_err tied 0.

Decomposition:
- Shared package holds:
  - fetch state enum (S_BOOT, S_IDLE, S_WAIT, S_FULL, S_DROP).
  - RESET_PC and EXC_VECTOR default constants.
  - NOP_WORD=32'h0.
- One natural sub-module: fetch_skid_buffer, a one-entry ir/pc4 holding register with load/unload/clear.

Test Plan:
- Reset release, latency-1 memory -> imem_req=1, addr 0x0 first cycle. Next cycle: IR=0x20080005, PC_plus_4=0x4, same-cycle req addr 0x4.
- Four back-to-back latency-1 responses at 0x0,0x4,0x8,0xC -> IR changes every cycle, PC_plus_4 = 0x4,0x8,0xC,0x10.
- stall=1 for 3 cycles while response for 0x8 arrives -> outputs equal mirror, S_FULL, no req. Release -> IR = skid word, PC_plus_4=0xC, req addr 0xC.
- redirect_valid with target 0x100 in S_WAIT, latency-3 junk response -> IF_ID_flush=1 that cycle, junk discarded, next req addr 0x100.
- exc_valid and redirect_valid (0x200) same cycle -> next req addr 0x8000_0004. With IMEM_TIMEOUT_EN and no rvalid for 64 cycles -> fetch_err=1, req addr 0x8000_0004.
- reset=0 mid-S_WAIT -> imem_req, IR, PC_plus_4 go 0 immediately, without a clock edge. Response after release is not captured as data.
